gate_score_counter: RTL and testbench

Live-score producer for the Flappy Bird datapath. Watches the bird/pipe collision logic's "inside gate column" level and, while a round is active, counts each new gate passage in three BCD digits (0–999). Drives the per-gate `pass` pulse and the three active-low 7-segment codes consumed by the high-score latch. It is the sending end of the score interface: it emits `pass` and the `HEX` inputs that the high-score block samples.

---
 rtl/flappy_pkg.sv | 50 +++++
 rtl/gate_score_counter_seg7_digit.sv | 18 +
 rtl/gate_score_counter.sv | 148 ++++++++++++++
 tb/tb_gate_score_counter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flappy_pkg
// Description : Shared types and constants for the Flappy Bird score path:
//               score FSM states, 7-segment codes and score width.
// Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    localparam int SCORE_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } score_state_t;

    // Active-low gfedcba codes
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/gate_score_counter_seg7_digit.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit
// Description : One BCD digit to active-low 7-segment code, with blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit
    import flappy_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg7_encode(bcd);

endmodule : seg7_digit
`default_nettype wire

// File: rtl/gate_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : gate_score_counter
// Description : Counts gate passages per round in three BCD digits and drives
//               the pass pulse, binary score and registered 7-seg codes.
//               Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_score_counter
    import flappy_pkg::*;
#(
    parameter int MAX_SCORE = 999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               gateIn,
    input  logic               gameOver,
    output logic               pass,
    output logic [SCORE_W-1:0] score,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic               playing
);

    localparam logic [SCORE_W-1:0] c_max_score = SCORE_W'(MAX_SCORE);

    score_state_t       r_state;
    score_state_t       w_state_nxt;
    logic               r_gate_q;
    logic [3:0]         r_ones;
    logic [3:0]         r_tens;
    logic [3:0]         r_huns;
    logic [SCORE_W-1:0] r_score;
    logic               r_pass;
    logic [6:0]         r_hex0;
    logic [6:0]         r_hex1;
    logic [6:0]         r_hex2;

    logic               w_event;
    logic               w_clear;
    logic               w_count;
    logic               w_blank1;
    logic               w_blank2;
    logic [6:0]         w_seg0;
    logic [6:0]         w_seg1;
    logic [6:0]         w_seg2;

    assign w_event = gateIn & ~r_gate_q;

    // gameOver has priority over a coincident gate event
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = PLAYING;
                    w_clear     = 1'b1;
                end
            end
            PLAYING: begin
                if (gameOver) begin
                    w_state_nxt = OVER;
                end else if (w_event && (r_score < c_max_score)) begin
                    w_count = 1'b1;
                end
            end
            OVER: begin
                if (start) begin
                    w_state_nxt = PLAYING;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign w_blank2 = (r_huns == 4'd0);
    assign w_blank1 = (r_huns == 4'd0) && (r_tens == 4'd0);
`else
    assign w_blank2 = 1'b0;
    assign w_blank1 = 1'b0;
`endif

    seg7_digit u_seg_ones (.bcd(r_ones), .blank(1'b0),     .seg(w_seg0));
    seg7_digit u_seg_tens (.bcd(r_tens), .blank(w_blank1), .seg(w_seg1));
    seg7_digit u_seg_huns (.bcd(r_huns), .blank(w_blank2), .seg(w_seg2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gate_q <= 1'b0;
            r_ones   <= 4'd0;
            r_tens   <= 4'd0;
            r_huns   <= 4'd0;
            r_score  <= '0;
            r_pass   <= 1'b0;
            r_hex0   <= SEG_0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            r_hex1   <= SEG_BLANK;
            r_hex2   <= SEG_BLANK;
`else
            r_hex1   <= SEG_0;
            r_hex2   <= SEG_0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gate_q <= gateIn;
            r_pass   <= w_count;
            // HEX follows the digits one cycle behind the count
            r_hex0   <= w_seg0;
            r_hex1   <= w_seg1;
            r_hex2   <= w_seg2;
            if (w_clear) begin
                r_ones  <= 4'd0;
                r_tens  <= 4'd0;
                r_huns  <= 4'd0;
                r_score <= '0;
            end else if (w_count) begin
                r_score <= r_score + SCORE_W'(1);
                if (r_ones == 4'd9) begin
                    r_ones <= 4'd0;
                    if (r_tens == 4'd9) begin
                        r_tens <= 4'd0;
                        r_huns <= r_huns + 4'd1;
                    end else begin
                        r_tens <= r_tens + 4'd1;
                    end
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end
        end
    end

    assign pass    = r_pass;
    assign score   = r_score;
    assign HEX0    = r_hex0;
    assign HEX1    = r_hex1;
    assign HEX2    = r_hex2;
    assign playing = (r_state == PLAYING);

endmodule : gate_score_counter
`default_nettype wire

// File: tb/tb_gate_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_score_counter
// Description : Scoreboard bench for gate_score_counter against a decimal
//               reference model of the round/score rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_score_counter;

    localparam int MAX = 999;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       gateIn = 1'b0;
    logic       gameOver = 1'b0;
    logic       pass;
    logic [9:0] score;
    logic [6:0] HEX0, HEX1, HEX2;
    logic       playing;

    int n_checks = 0;
    int n_fail   = 0;
    int pass_cnt = 0;

    // Reference model: 0 = waiting, 1 = in round, 2 = round over
    int  m_mode   = 0;
    int  m_count  = 0;
    int  m_shown  = 0;
    bit  m_gprev  = 1'b0;
    bit  m_pass   = 1'b0;
    int  exp_q[$];

    int seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    gate_score_counter #(.MAX_SCORE(MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .gateIn(gateIn),
        .gameOver(gameOver), .pass(pass), .score(score),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .playing(playing)
    );

    always #5 clk = ~clk;

    function automatic int exp_hex(input int v, input int pos);
        int  d;
        bit  blank;
        d = (pos == 0) ? (v % 10) : (pos == 1) ? ((v / 10) % 10) : ((v / 100) % 10);
        blank = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (pos == 2 && v < 100) blank = 1'b1;
        if (pos == 1 && v < 10)  blank = 1'b1;
`endif
        return blank ? 127 : seg_tab[d];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  = 0;
            m_count = 0;
            m_shown = 0;
            m_gprev = 1'b0;
            m_pass  = 1'b0;
        end else begin
            m_shown = m_count;
            m_pass  = 1'b0;
            if (m_mode == 1) begin
                if (gameOver) begin
                    m_mode = 2;
                end else if (gateIn && !m_gprev && m_count < MAX) begin
                    m_count = m_count + 1;
                    m_pass  = 1'b1;
                    exp_q.push_back(m_count);
                end
            end else if (start) begin
                m_mode  = 1;
                m_count = 0;
            end
            m_gprev = gateIn;
        end
    end

    always @(negedge clk) begin
        check("score", int'(score), m_count);
        check("playing", int'(playing), (m_mode == 1) ? 1 : 0);
        check("pass", int'(pass), int'(m_pass));
        check("HEX0", int'(HEX0), exp_hex(m_shown, 0));
        check("HEX1", int'(HEX1), exp_hex(m_shown, 1));
        check("HEX2", int'(HEX2), exp_hex(m_shown, 2));
        if (pass) begin
            pass_cnt++;
            check("pass_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) check("pass_score", int'(score), exp_q.pop_front());
        end else if (exp_q.size() > 0) begin
            check("missing_pass", int'(pass), 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gate_pulse();
        gateIn = 1'b1;
        tick();
        gateIn = 1'b0;
        tick();
    endtask

    task automatic new_round();
        gameOver = 1'b1;
        tick();
        gameOver = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tick();
        tick();
        check("rst_score", int'(score), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_HEX0", int'(HEX0), 7'b1000000);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        check("rst_HEX1", int'(HEX1), 7'b1111111);
        check("rst_HEX2", int'(HEX2), 7'b1111111);
`else
        check("rst_HEX1", int'(HEX1), 7'b1000000);
        check("rst_HEX2", int'(HEX2), 7'b1000000);
`endif
        reset = 1'b0;
        tick();

        // Twelve isolated gate pulses
        new_round();
        p0 = pass_cnt;
        for (int i = 0; i < 12; i++) begin
            gate_pulse();
            tick();
        end
        check("t1_passes", pass_cnt - p0, 12);
        check("t1_score", int'(score), 12);
        check("t1_HEX0", int'(HEX0), 7'b0100100);
        check("t1_HEX1", int'(HEX1), 7'b1111001);
        check("t1_HEX2", int'(HEX2), exp_hex(12, 2));

        // Held level counts once
        new_round();
        p0 = pass_cnt;
        gateIn = 1'b1;
        repeat (20) tick();
        gateIn = 1'b0;
        tick();
        check("t2_passes", pass_cnt - p0, 1);
        check("t2_score", int'(score), 1);

        // gameOver beats a coincident gate rise
        new_round();
        repeat (5) gate_pulse();
        p0 = pass_cnt;
        gateIn = 1'b1;
        gameOver = 1'b1;
        tick();
        gateIn = 1'b0;
        gameOver = 1'b0;
        tick();
        gate_pulse();
        check("t4_passes", pass_cnt - p0, 0);
        check("t4_score", int'(score), 5);
        check("t4_playing", int'(playing), 0);

        // Restart from OVER clears count
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_score", int'(score), 0);
        tick();
        check("t5_HEX0", int'(HEX0), 7'b1000000);
        gate_pulse();
        check("t5_resume", int'(score), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            gateIn   = ($urandom_range(0, 1) == 1);
            gameOver = ($urandom_range(0, 24) == 0);
            start    = ($urandom_range(0, 19) == 0);
            tick();
        end
        gateIn = 1'b0;
        gameOver = 1'b0;
        start = 1'b0;
        tick();

        // Reset mid-round coincident with a gate rise
        new_round();
        repeat (40) gate_pulse();
        check("t6_pre", int'(score), 40);
        gateIn = 1'b1;
        reset = 1'b1;
        #1;
        check("t6_score", int'(score), 0);
        check("t6_pass", int'(pass), 0);
        check("t6_playing", int'(playing), 0);
        tick();
        reset = 1'b0;
        gateIn = 1'b0;
        tick();

        // Saturation at MAX
        new_round();
        repeat (998) gate_pulse();
        check("t3_pre", int'(score), 998);
        p0 = pass_cnt;
        repeat (3) gate_pulse();
        check("t3_passes", pass_cnt - p0, 1);
        check("t3_score", int'(score), 999);
        check("t3_HEX0", int'(HEX0), 7'b0010000);
        check("t3_HEX1", int'(HEX1), 7'b0010000);
        check("t3_HEX2", int'(HEX2), 7'b0010000);

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gate_score_counter
`default_nettype wire
